// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS-style EX stage: ALU opcodes, destination select
// and the multiply/divide sequencer states.
package mips_pkg;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_SUB   = 3'b001,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_SLT   = 3'b100,
        ALU_MULTU = 3'b101,
        ALU_DIVU  = 3'b110,
        ALU_MDR   = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        RDST_RT   = 2'b00,
        RDST_RD   = 2'b01,
        RDST_RA   = 2'b10,
        RDST_ZERO = 2'b11
    } reg_dst_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/md_unit.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) with HI/LO.
// One iteration per cycle; HI/LO are written only on the final iteration.
module md_unit
    import mips_pkg::*;
#(
    parameter int W       = 32,
    parameter int MD_ITER = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         is_div,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int CNT_W = (MD_ITER > 1) ? $clog2(MD_ITER) : 1;

    md_state_e      state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic           is_div_r;
    // opnd_r holds the multiplicand or the divisor; acc_lo_r starts as multiplier or dividend
    logic [W-1:0]   opnd_r, acc_hi_r, acc_lo_r, hi_r, lo_r;
    logic [W-1:0]   iter_hi_s, iter_lo_s;
    logic [W:0]     mul_sum_s, div_shift_s, div_diff_s;

    // Single iteration of the shared mul/div datapath
    always_comb begin
        mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opnd_r} : {(W+1){1'b0}});
        div_shift_s = {acc_hi_r, acc_lo_r[W-1]};
        div_diff_s  = div_shift_s - {1'b0, opnd_r};
        iter_hi_s   = acc_hi_r;
        iter_lo_s   = acc_lo_r;
        if (is_div_r) begin
            if (!div_diff_s[W]) begin
                iter_hi_s = div_diff_s[W-1:0];
                iter_lo_s = {acc_lo_r[W-2:0], 1'b1};
            end else begin
                iter_hi_s = div_shift_s[W-1:0];
                iter_lo_s = {acc_lo_r[W-2:0], 1'b0};
            end
        end else begin
            iter_hi_s = mul_sum_s[W:1];
            iter_lo_s = {mul_sum_s[0], acc_lo_r[W-1:1]};
        end
    end

    // Next-state logic: a held op in DONE never restarts the sequencer
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            MD_IDLE: begin
                if (start) state_nxt_s = MD_BUSY;
                else       state_nxt_s = MD_IDLE;
            end
            MD_BUSY: begin
                if (cnt_r == {CNT_W{1'b0}}) state_nxt_s = MD_DONE;
                else                        state_nxt_s = MD_BUSY;
            end
            MD_DONE: state_nxt_s = MD_IDLE;
            default: state_nxt_s = MD_IDLE;
        endcase
    end

    // State, operand latch, accumulators, iteration counter and HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= MD_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            is_div_r <= 1'b0;
            opnd_r   <= {W{1'b0}};
            acc_hi_r <= {W{1'b0}};
            acc_lo_r <= {W{1'b0}};
            hi_r     <= {W{1'b0}};
            lo_r     <= {W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            case (state_r)
                MD_IDLE: begin
                    if (start) begin
                        is_div_r <= is_div;
                        opnd_r   <= is_div ? b : a;
                        acc_hi_r <= {W{1'b0}};
                        acc_lo_r <= is_div ? a : b;
                        cnt_r    <= CNT_W'(MD_ITER - 1);
                    end
                end
                MD_BUSY: begin
                    acc_hi_r <= iter_hi_s;
                    acc_lo_r <= iter_lo_s;
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        hi_r <= iter_hi_s;
                        lo_r <= iter_lo_s;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_r != MD_IDLE);
    assign done = (state_r == MD_DONE);
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: rtl/ex_stage_md.sv
// EX stage: operand forwarding, single-cycle ALU, destination select and
// the stall control around the iterative multiply/divide unit.
module ex_stage_md
    import mips_pkg::*;
#(
    parameter int W       = 32,
    parameter int MD_ITER = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   alu_op,
    input  logic         alu_src,
    input  logic         md_sel,
    input  logic [1:0]   reg_dst,
    input  logic [W-1:0] read_data1,
    input  logic [W-1:0] read_data2,
    input  logic [W-1:0] sgn_ext,
    input  logic [4:0]   rs,
    input  logic [4:0]   rt,
    input  logic [4:0]   rd,
    input  logic         exmem_wr,
    input  logic [4:0]   exmem_rd,
    input  logic [W-1:0] exmem_val,
    input  logic         memwb_wr,
    input  logic [4:0]   memwb_rd,
    input  logic [W-1:0] memwb_val,
    output logic [W-1:0] alu_result,
    output logic [W-1:0] store_data,
    output logic [4:0]   write_reg,
    output logic         stall_o,
    output logic         md_busy
);

    logic [W-1:0] fwd_a_s, fwd_b_s, alu_b_s, md_hi_s, md_lo_s;
    logic         md_start_s, md_is_div_s, md_busy_s, md_done_s;

    // Operand forwarding; the younger EX/MEM value takes priority over MEM/WB
    always_comb begin
        fwd_a_s = read_data1;
        if (exmem_wr && (exmem_rd == rs) && (exmem_rd != 5'd0)) begin
            fwd_a_s = exmem_val;
        end else if (memwb_wr && (memwb_rd == rs) && (memwb_rd != 5'd0)) begin
            fwd_a_s = memwb_val;
        end else begin
            fwd_a_s = read_data1;
        end
        fwd_b_s = read_data2;
        if (exmem_wr && (exmem_rd == rt) && (exmem_rd != 5'd0)) begin
            fwd_b_s = exmem_val;
        end else if (memwb_wr && (memwb_rd == rt) && (memwb_rd != 5'd0)) begin
            fwd_b_s = memwb_val;
        end else begin
            fwd_b_s = read_data2;
        end
    end

    assign alu_b_s     = alu_src ? sgn_ext : fwd_b_s;
    assign md_start_s  = (alu_op == ALU_MULTU) || (alu_op == ALU_DIVU);
    assign md_is_div_s = (alu_op == ALU_DIVU);

    md_unit #(.W(W), .MD_ITER(MD_ITER)) u_md (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start_s),
        .is_div (md_is_div_s),
        .a      (fwd_a_s),
        .b      (alu_b_s),
        .busy   (md_busy_s),
        .done   (md_done_s),
        .hi     (md_hi_s),
        .lo     (md_lo_s)
    );

    // Single-cycle ALU and HI/LO read-out
    always_comb begin
        alu_result = {W{1'b0}};
        case (alu_op)
            ALU_ADD:   alu_result = fwd_a_s + alu_b_s;
            ALU_SUB:   alu_result = fwd_a_s - alu_b_s;
            ALU_AND:   alu_result = fwd_a_s & alu_b_s;
            ALU_OR:    alu_result = fwd_a_s | alu_b_s;
            ALU_SLT:   alu_result = {{(W-1){1'b0}}, (fwd_a_s < alu_b_s)};
            ALU_MDR:   alu_result = md_sel ? md_hi_s : md_lo_s;
            default:   alu_result = {W{1'b0}};
        endcase
    end

    // Destination register select
    always_comb begin
        write_reg = rt;
        case (reg_dst)
            RDST_RT:   write_reg = rt;
            RDST_RD:   write_reg = rd;
            RDST_RA:   write_reg = REG_RA;
            RDST_ZERO: write_reg = 5'd0;
            default:   write_reg = 5'd0;
        endcase
    end

    // Stall on issue and through BUSY; DONE lets the held op leave EX
    assign stall_o    = md_busy_s ? !md_done_s : md_start_s;
    assign md_busy    = md_busy_s;
    assign store_data = fwd_b_s;

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed bench for ex_stage_md: table of combinational vectors plus
// hand-written multiply/divide, reset and back-to-back sequences.
module tb_ex_stage_md;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  alu_op;
    logic        alu_src, md_sel;
    logic [1:0]  reg_dst;
    logic [31:0] read_data1, read_data2, sgn_ext;
    logic [4:0]  rs, rt, rd;
    logic        exmem_wr, memwb_wr;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_val, memwb_val;
    logic [31:0] alu_result, store_data;
    logic [4:0]  write_reg;
    logic        stall_o, md_busy;

    int n_checks = 0;
    int n_fail   = 0;

    ex_stage_md #(.W(32), .MD_ITER(32)) dut (
        .clk(clk), .rst(rst), .alu_op(alu_op), .alu_src(alu_src), .md_sel(md_sel),
        .reg_dst(reg_dst), .read_data1(read_data1), .read_data2(read_data2),
        .sgn_ext(sgn_ext), .rs(rs), .rt(rt), .rd(rd),
        .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_val(exmem_val),
        .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_val(memwb_val),
        .alu_result(alu_result), .store_data(store_data), .write_reg(write_reg),
        .stall_o(stall_o), .md_busy(md_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic        src;
        logic [1:0]  dst;
        logic [4:0]  rs, rt;
        logic [31:0] rd1, rd2, imm;
        logic        exwr;
        logic [4:0]  exrd;
        logic [31:0] exval;
        logic        wbwr;
        logic [4:0]  wbrd;
        logic [31:0] wbval;
        logic [31:0] exp_res;
        logic [4:0]  exp_wreg;
        logic [31:0] exp_sd;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic read_md(input logic sel, output logic [31:0] val);
        alu_op = 3'b111;
        md_sel = sel;
        #1;
        val = alu_result;
    endtask

    // Called #1 after a posedge; returns #1 after the posedge ending the DONE cycle
    task automatic issue_md(input string name, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b);
        int  n;
        bit  fin;
        n = 0;
        fin = 1'b0;
        alu_op = op; alu_src = 1'b0; rs = 5'd1; rt = 5'd2;
        read_data1 = a; read_data2 = b;
        exmem_wr = 1'b0; memwb_wr = 1'b0;
        for (int i = 0; i < 100 && !fin; i++) begin
            @(negedge clk);
            if (stall_o) n++;
            else         fin = 1'b1;
            if (!fin) begin
                @(posedge clk); #1;
                read_data1 = 32'hDEAD_BEEF;
                read_data2 = 32'h1234_5678;
            end
        end
        check({name, " stall cycles"}, 32'(n), 32'd33);
        check({name, " busy in DONE"}, {31'd0, md_busy}, 32'd1);
        @(posedge clk); #1;
        check({name, " no restart"}, {31'd0, md_busy}, 32'd0);
        alu_op = 3'b000;
    endtask

    initial begin
        logic [31:0] v;

        vecs[0]  = '{3'b000, 1'b1, 2'b01, 5'd5, 5'd0, 32'd100, 32'd0, 32'd1, 1'b1, 5'd5, 32'd7, 1'b1, 5'd5, 32'd9, 32'd8, 5'd4, 32'd0};
        vecs[1]  = '{3'b000, 1'b1, 2'b01, 5'd0, 5'd0, 32'd100, 32'd0, 32'd1, 1'b1, 5'd0, 32'd7, 1'b1, 5'd0, 32'd9, 32'd101, 5'd4, 32'd0};
        vecs[2]  = '{3'b000, 1'b1, 2'b01, 5'd5, 5'd0, 32'd100, 32'd0, 32'd1, 1'b0, 5'd5, 32'd7, 1'b1, 5'd5, 32'd9, 32'd10, 5'd4, 32'd0};
        vecs[3]  = '{3'b000, 1'b1, 2'b01, 5'd5, 5'd0, 32'd100, 32'd0, 32'd1, 1'b0, 5'd5, 32'd7, 1'b0, 5'd5, 32'd9, 32'd101, 5'd4, 32'd0};
        vecs[4]  = '{3'b001, 1'b0, 2'b00, 5'd1, 5'd2, 32'd10, 32'd3, 32'd0, 1'b1, 5'd2, 32'd4, 1'b1, 5'd2, 32'd9, 32'd6, 5'd2, 32'd4};
        vecs[5]  = '{3'b001, 1'b0, 2'b00, 5'd1, 5'd2, 32'd10, 32'd3, 32'd0, 1'b0, 5'd2, 32'd4, 1'b1, 5'd2, 32'd5, 32'd5, 5'd2, 32'd5};
        vecs[6]  = '{3'b001, 1'b0, 2'b01, 5'd1, 5'd3, 32'd0, 32'd1, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'hFFFF_FFFF, 5'd4, 32'd1};
        vecs[7]  = '{3'b100, 1'b0, 2'b00, 5'd1, 5'd3, 32'd2, 32'd3, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd1, 5'd3, 32'd3};
        vecs[8]  = '{3'b100, 1'b0, 2'b00, 5'd1, 5'd3, 32'd3, 32'd2, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd3, 32'd2};
        vecs[9]  = '{3'b100, 1'b0, 2'b00, 5'd1, 5'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd3, 32'd1};
        vecs[10] = '{3'b010, 1'b0, 2'b10, 5'd1, 5'd3, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h0000_F000, 5'd31, 32'h0000_FF00};
        vecs[11] = '{3'b011, 1'b0, 2'b11, 5'd1, 5'd3, 32'h0000_F0F0, 32'h0000_FF00, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h0000_FFF0, 5'd0, 32'h0000_FF00};
        vecs[12] = '{3'b000, 1'b0, 2'b01, 5'd1, 5'd3, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd4, 32'd1};
        vecs[13] = '{3'b000, 1'b1, 2'b00, 5'd1, 5'd3, 32'd5, 32'd99, 32'h10, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'h15, 5'd3, 32'd99};
        vecs[14] = '{3'b111, 1'b0, 2'b00, 5'd1, 5'd3, 32'd5, 32'd99, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd3, 32'd99};

        rst = 1'b1; alu_op = 3'b000; alu_src = 1'b0; md_sel = 1'b0; reg_dst = 2'b00;
        read_data1 = 32'd0; read_data2 = 32'd0; sgn_ext = 32'd0;
        rs = 5'd0; rt = 5'd0; rd = 5'd4;
        exmem_wr = 1'b0; exmem_rd = 5'd0; exmem_val = 32'd0;
        memwb_wr = 1'b0; memwb_rd = 5'd0; memwb_val = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset stall_o", {31'd0, stall_o}, 32'd0);
        check("reset md_busy", {31'd0, md_busy}, 32'd0);

        foreach (vecs[i]) begin
            alu_op = vecs[i].op; alu_src = vecs[i].src; reg_dst = vecs[i].dst; md_sel = 1'b0;
            rs = vecs[i].rs; rt = vecs[i].rt; rd = 5'd4;
            read_data1 = vecs[i].rd1; read_data2 = vecs[i].rd2; sgn_ext = vecs[i].imm;
            exmem_wr = vecs[i].exwr; exmem_rd = vecs[i].exrd; exmem_val = vecs[i].exval;
            memwb_wr = vecs[i].wbwr; memwb_rd = vecs[i].wbrd; memwb_val = vecs[i].wbval;
            #2;
            check($sformatf("vec%0d alu_result", i), alu_result, vecs[i].exp_res);
            check($sformatf("vec%0d write_reg", i), {27'd0, write_reg}, {27'd0, vecs[i].exp_wreg});
            check($sformatf("vec%0d store_data", i), store_data, vecs[i].exp_sd);
            check($sformatf("vec%0d stall_o", i), {31'd0, stall_o}, 32'd0);
        end

        alu_op = 3'b000;
        @(posedge clk); #1;
        issue_md("multu max", 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        read_md(1'b1, v); check("multu max HI", v, 32'hFFFF_FFFE);
        read_md(1'b0, v); check("multu max LO", v, 32'h0000_0001);

        // MULTU followed immediately by DIVU
        alu_op = 3'b000;
        issue_md("b2b multu", 3'b101, 32'd6, 32'd7);
        issue_md("b2b divu", 3'b110, 32'd100, 32'd7);
        read_md(1'b0, v); check("divu 100/7 LO", v, 32'd14);
        read_md(1'b1, v); check("divu 100/7 HI", v, 32'd2);

        issue_md("divu by 0", 3'b110, 32'd5, 32'd0);
        read_md(1'b0, v); check("divu 5/0 LO", v, 32'hFFFF_FFFF);
        read_md(1'b1, v); check("divu 5/0 HI", v, 32'd5);

        // Reset in BUSY cycle 10
        @(posedge clk); #1;
        alu_op = 3'b101; rs = 5'd1; rt = 5'd2; alu_src = 1'b0;
        read_data1 = 32'hFFFF_FFFF; read_data2 = 32'd2;
        repeat (10) @(posedge clk);
        #1;
        check("busy before rst", {31'd0, md_busy}, 32'd1);
        rst = 1'b1; alu_op = 3'b111;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst stall_o", {31'd0, stall_o}, 32'd0);
        check("rst md_busy", {31'd0, md_busy}, 32'd0);
        read_md(1'b1, v); check("rst HI", v, 32'd0);
        read_md(1'b0, v); check("rst LO", v, 32'd0);

        issue_md("multu 3*4", 3'b101, 32'd3, 32'd4);
        read_md(1'b0, v); check("multu 3*4 LO", v, 32'd12);
        read_md(1'b1, v); check("multu 3*4 HI", v, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
